// File: rtl/pulse_delay_tagger.sv
// Start-to-stop delay tagger: measures ticks between a start and a stop pulse,
// reports the delay on a valid/ready port and keeps saturating timeout/drop counts.
module pulse_delay_tagger #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MAX_DELAY = 200,
    parameter int unsigned STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              start_pulse,
    input  logic              stop_pulse,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  delay_out,
    output logic [STAT_W-1:0] timeout_count,
    output logic [STAT_W-1:0] drop_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_DELAY);
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
    localparam logic [STAT_W-1:0] STAT_TOP = '1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  delay_q, delay_d;
    logic [STAT_W-1:0] timeout_q, timeout_d;
    logic [STAT_W-1:0] drop_q, drop_d;

    logic [STAT_W-1:0] timeout_inc;
    logic [STAT_W-1:0] drop_inc;

    // Statistics stick at all-ones instead of wrapping.
    assign timeout_inc = (timeout_q == STAT_TOP) ? timeout_q : timeout_q + STAT_ONE;
    assign drop_inc    = (drop_q == STAT_TOP) ? drop_q : drop_q + STAT_ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        delay_d     = delay_q;
        timeout_d   = timeout_q;
        drop_d      = drop_q;

        case (state_q)
            IDLE: begin
                if (enable && start_pulse) begin
                    if (stop_pulse) begin
                        state_d     = REPORT;
                        delay_d     = '0;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ARMED;
                        cnt_d   = CNT_ONE;
                    end
                end
            end

            ARMED: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (stop_pulse) begin
                    // Stop measures the pending start; a coincident new start is lost.
                    state_d     = REPORT;
                    delay_d     = cnt_q;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    if (start_pulse) begin
                        drop_d = drop_inc;
                    end
                end else if (start_pulse) begin
                    cnt_d = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = timeout_inc;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            REPORT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (enable && start_pulse) begin
                        state_d = ARMED;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (enable && start_pulse) begin
                    drop_d = drop_inc;
                end
            end

            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            delay_q     <= '0;
            timeout_q   <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            delay_q     <= delay_d;
            timeout_q   <= timeout_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign delay_out     = delay_q;
    assign timeout_count = timeout_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_pulse_delay_tagger.sv
// Scoreboard bench for pulse_delay_tagger: expected delays are queued when the
// stop is driven and compared when the DUT hands a result over.
module tb_pulse_delay_tagger;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        start_pulse = 1'b0;
    logic        stop_pulse = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  delay_out;
    logic [15:0] timeout_count;
    logic [15:0] drop_count;

    logic        s_start = 1'b0;
    logic        s_valid;
    logic [7:0]  s_delay;
    logic [3:0]  s_timeout;
    logic [3:0]  s_drop;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    pulse_delay_tagger #(.CNT_W(8), .MAX_DELAY(200), .STAT_W(16)) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .start_pulse(start_pulse), .stop_pulse(stop_pulse),
        .out_valid(out_valid), .out_ready(out_ready), .delay_out(delay_out),
        .timeout_count(timeout_count), .drop_count(drop_count)
    );

    // Small-window, narrow-statistics copy used to reach saturation quickly.
    pulse_delay_tagger #(.CNT_W(8), .MAX_DELAY(1), .STAT_W(4)) u_sat (
        .clk(clk), .rst(rst), .enable(1'b1),
        .start_pulse(s_start), .stop_pulse(1'b0),
        .out_valid(s_valid), .out_ready(1'b1), .delay_out(s_delay),
        .timeout_count(s_timeout), .drop_count(s_drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start, then stop k cycles later; the reported delay must be k.
    task automatic measure(input int k);
        start_pulse = 1'b1;
        if (k == 0) begin
            stop_pulse = 1'b1;
            exp_q.push_back(0);
            tick();
            start_pulse = 1'b0;
            stop_pulse  = 1'b0;
        end else begin
            tick();
            start_pulse = 1'b0;
            repeat (k - 1) tick();
            stop_pulse = 1'b1;
            exp_q.push_back(k);
            tick();
            stop_pulse = 1'b0;
        end
    endtask

    // Handshake monitor: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(delay_out), 32'hFFFF_FFFF);
            end else begin
                check("delay_out", 32'(delay_out), exp_q.pop_front());
            end
        end
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_delay_out", 32'(delay_out), 0);
        check("rst_timeout", 32'(timeout_count), 0);
        check("rst_drop", 32'(drop_count), 0);
        repeat (2) tick();
        rst = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;
        repeat (2) tick();

        // Saturation: 15 timeouts fill a 4-bit counter, further ones must not wrap.
        for (int i = 0; i < 17; i++) begin
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
            tick();
            if (i == 14) check("sat_timeout_15", 32'(s_timeout), 15);
        end
        check("sat_timeout_hold", 32'(s_timeout), 15);
        check("sat_no_result", 32'(s_valid), 0);

        // Basic 25-tick measurement with one-cycle valid pulse.
        measure(25);
        check("lat_valid_high", 32'(out_valid), 1);
        check("lat_delay", 32'(delay_out), 25);
        tick();
        check("lat_valid_low", 32'(out_valid), 0);
        repeat (3) tick();

        // Window boundaries.
        measure(0);
        tick();
        measure(200);
        tick();
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        repeat (200) tick();
        stop_pulse = 1'b1;
        tick();
        stop_pulse = 1'b0;
        check("late_stop_no_valid", 32'(out_valid), 0);
        check("timeout_one", 32'(timeout_count), 1);
        repeat (3) tick();

        // Back-pressure with drops, then handshake coincident with a new start.
        out_ready = 1'b0;
        measure(7);
        for (int i = 0; i < 3; i++) begin
            start_pulse = 1'b1;
            tick();
            start_pulse = 1'b0;
            tick();
        end
        check("hold_valid", 32'(out_valid), 1);
        check("hold_delay", 32'(delay_out), 7);
        check("drop_three", 32'(drop_count), 3);
        out_ready   = 1'b1;
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        check("hs_start_valid_low", 32'(out_valid), 0);
        check("hs_start_drop", 32'(drop_count), 3);
        repeat (3) tick();
        stop_pulse = 1'b1;
        exp_q.push_back(4);
        tick();
        stop_pulse = 1'b0;
        check("rearm_valid", 32'(out_valid), 1);
        repeat (3) tick();

        // Retrigger: second start restarts the measurement, no timeout counted.
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        repeat (49) tick();
        measure(10);
        repeat (2) tick();
        check("retrig_timeout", 32'(timeout_count), 1);

        // Stop and start together while armed: old start measured, new one dropped.
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        repeat (5) tick();
        start_pulse = 1'b1;
        stop_pulse  = 1'b1;
        exp_q.push_back(6);
        tick();
        start_pulse = 1'b0;
        stop_pulse  = 1'b0;
        check("coinc_drop", 32'(drop_count), 4);
        repeat (3) tick();

        // Enable low mid-measurement aborts silently.
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        repeat (5) tick();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (5) tick();
        stop_pulse = 1'b1;
        tick();
        stop_pulse = 1'b0;
        tick();
        check("abort_no_valid", 32'(out_valid), 0);
        check("abort_timeout", 32'(timeout_count), 1);
        check("abort_drop", 32'(drop_count), 4);
        check("queue_drained", 32'(exp_q.size()), 0);

        // Asynchronous reset drops a pending result immediately.
        out_ready = 1'b0;
        measure(5);
        check("pre_rst_valid", 32'(out_valid), 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_timeout", 32'(timeout_count), 0);
        check("async_rst_drop", 32'(drop_count), 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        stop_pulse = 1'b1;
        tick();
        stop_pulse = 1'b0;
        repeat (3) tick();
        check("stop_alone_no_valid", 32'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_delay_tagger.md
Name: pulse_delay_tagger

Overview:
- Downstream consumer of the detector pulse shapers.
- Takes two shaped 1-cycle pulse streams, start (herald/reference) and stop (signal photon), both synchronous to the 500 MHz clk.
- Measures the start-to-stop delay in clk ticks (2 ns resolution) and presents it on a valid/ready interface to the histogram/readout logic.
- Also keeps saturating counts of timeouts and events lost while a result is pending.

Parameters:
- CNT_W, 8: width of the delay counter and of delay_out.
- MAX_DELAY, 200: coincidence window in ticks (400 ns). Must satisfy 1 <= MAX_DELAY < 2^CNT_W.
- STAT_W, 16: width of the timeout and drop statistics counters.

Ports:
- clk  in  1  500 MHz system clock, rising edge.
- rst  in  1  asynchronous reset, active-high. Returns all state to reset values immediately.
- enable  in  1  high = accept start pulses; low = ignore starts and abort any running measurement.
- start_pulse  in  1  1-cycle pulse from the start-channel shaper.
- stop_pulse  in  1  1-cycle pulse from the stop-channel shaper.
- out_valid  out  1  delay_out holds a result.
- out_ready  in  1  consumer accepts the result on a cycle where out_valid && out_ready.
- delay_out  out  CNT_W  measured delay in ticks.
- timeout_count  out  STAT_W  starts with no stop within MAX_DELAY. Saturating.
- drop_count  out  STAT_W  start pulses discarded while in REPORT. Saturating.

Behaviour:
- Reset values: state = IDLE, cnt = 0, out_valid = 0, delay_out = 0, timeout_count = 0, drop_count = 0.
- IDLE
  - enable && start_pulse && stop_pulse in the same cycle: go to REPORT with delay_out = 0.
  - enable && start_pulse only: go to ARMED with cnt = 1.
  - stop_pulse alone: ignored.
- ARMED (cnt = ticks elapsed since the start cycle)
  - enable low: go to IDLE, no report, no statistics change.
  - stop_pulse: go to REPORT with delay_out = cnt. A start at cycle t and a stop at cycle t+k reports k.
  - else if cnt == MAX_DELAY: go to IDLE, timeout_count += 1 (saturating). A stop at t+MAX_DELAY is still captured; a stop at t+MAX_DELAY+1 is not.
  - else: cnt += 1.
  - start_pulse with no stop: retrigger, cnt = 1. No timeout is counted for the abandoned start.
  - start_pulse and stop_pulse in the same cycle: the stop wins, the old start is measured, and the new start is dropped (drop_count += 1).
- REPORT
  - out_valid = 1. delay_out is held stable until the handshake.
  - Handshake: go to IDLE, out_valid = 0 the next cycle.
  - Handshake && enable && start_pulse in the same cycle: go directly to ARMED with cnt = 1; not counted as a drop.
  - Otherwise every start_pulse while in REPORT (with enable high) increments drop_count (saturating). stop_pulse is ignored.
  - enable low in REPORT does not withdraw a pending result.
- Latency: out_valid rises on the clk edge after the stop cycle.
- Statistics counters saturate at 2^STAT_W-1 and never wrap. Only rst clears them.
- Reset mid-operation: any state, including REPORT with a pending result, goes to IDLE with out_valid = 0 immediately. The result is lost.
- cnt never exceeds MAX_DELAY, so there is no wrap-around in the counter.

Test Plan:
- Start at cycle 10, stop at cycle 35, out_ready = 1 -> out_valid high for 1 cycle starting cycle 36, delay_out = 25; then IDLE.
- Start and stop in the same cycle from IDLE -> delay_out = 0. Stop at start+200 -> delay_out = 200. Stop at start+201 -> no out_valid, timeout_count = 1.
- out_ready = 0 after a result of 7; three further starts -> delay_out stays 7, drop_count = 3. Raise out_ready together with a start -> the handshake completes, the block is ARMED, drop_count stays 3.
- Start at t, second start at t+50, stop at t+60 -> delay_out = 10, timeout_count = 0. enable dropped mid-ARMED -> no result, counters unchanged.
- Assert rst while out_valid = 1 -> out_valid = 0 and counters = 0 immediately, without waiting for a clk edge. After release, a stop alone produces no output.
- Force 65535 timeouts, then one more -> timeout_count stays at 65535.
